// File: rtl/fence_pkg.sv
// Shared definitions for the FENCE ordering tracker.
// Holds the mask bit positions, the FSM state type and the mask-to-class mapping.
package fence_pkg;

  localparam int FENCE_I = 3;
  localparam int FENCE_O = 2;
  localparam int FENCE_R = 1;
  localparam int FENCE_W = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Device input folds into the load class, device output into the store class.
  function automatic logic [1:0] mask_to_class(input logic [3:0] mask);
    return {mask[FENCE_I] | mask[FENCE_R], mask[FENCE_O] | mask[FENCE_W]};
  endfunction

endpackage

// File: rtl/outstanding_counter.sv
// Saturating count of in-flight accesses for one class.
// Reports a one-cycle error pulse on an underflow or overflow attempt.
module outstanding_counter #(
  parameter int MAX = 8,
  localparam int W = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         err_pulse
);

  localparam logic [W-1:0] MAX_W = W'(MAX);

  logic [W-1:0] r_count;
  logic         w_underflow;
  logic         w_overflow;

  // An issue paired with a retire cancels out, even at the limits.
  assign w_underflow = dec & ~inc & (r_count == '0);
  assign w_overflow  = inc & ~dec & (r_count == MAX_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc & ~dec & ~w_overflow) begin
      r_count <= r_count + 1'b1;
    end else if (dec & ~inc & ~w_underflow) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign count     = r_count;
  assign full      = (r_count == MAX_W);
  assign err_pulse = w_underflow | w_overflow;

endmodule

// File: rtl/mem_fence_tracker.sv
// Memory-side FENCE responder: holds the ack until predecessor classes drain
// and stalls successor-class issue while the fence is pending.
module mem_fence_tracker
  import fence_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8,
  localparam int W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fence_req,
  input  logic [3:0]   fence_pred,
  input  logic [3:0]   fence_succ,
  output logic         fence_ack,
  output logic         fence_busy,
  input  logic         ld_issue,
  input  logic         ld_done,
  input  logic         st_issue,
  input  logic         st_done,
  output logic         ld_stall,
  output logic         st_stall,
  output logic [W-1:0] ld_count,
  output logic [W-1:0] st_count,
  output logic         err
);

  state_t     r_state;
  logic       r_need_ld;
  logic       r_need_st;
  logic       r_blk_ld;
  logic       r_blk_st;
  logic       r_err;

  logic [1:0] w_pred_cls;
  logic [1:0] w_succ_cls;
  logic       w_ld_full;
  logic       w_st_full;
  logic       w_ld_err;
  logic       w_st_err;
  logic       w_drained;

  outstanding_counter #(.MAX(MAX_OUTSTANDING)) u_ld_ctr (
    .clk      (clk),
    .rst      (rst),
    .inc      (ld_issue),
    .dec      (ld_done),
    .count    (ld_count),
    .full     (w_ld_full),
    .err_pulse(w_ld_err)
  );

  outstanding_counter #(.MAX(MAX_OUTSTANDING)) u_st_ctr (
    .clk      (clk),
    .rst      (rst),
    .inc      (st_issue),
    .dec      (st_done),
    .count    (st_count),
    .full     (w_st_full),
    .err_pulse(w_st_err)
  );

  assign w_pred_cls = mask_to_class(fence_pred);
  assign w_succ_cls = mask_to_class(fence_succ);

  // Drain looks only at registered counts, so a retire becomes visible a cycle later.
  assign w_drained = (~r_need_ld | (ld_count == '0)) & (~r_need_st | (st_count == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_need_ld <= 1'b0;
      r_need_st <= 1'b0;
      r_blk_ld  <= 1'b0;
      r_blk_st  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (fence_req) begin
            r_need_ld <= w_pred_cls[1];
            r_need_st <= w_pred_cls[0];
            r_blk_ld  <= w_succ_cls[1];
            r_blk_st  <= w_succ_cls[0];
            r_state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_drained) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_ld_err | w_st_err) begin
      r_err <= 1'b1;
    end
  end

  assign fence_busy = (r_state == DRAIN);
  assign fence_ack  = (r_state == DRAIN) & w_drained;
  assign ld_stall   = ((r_state == DRAIN) & r_blk_ld) | w_ld_full;
  assign st_stall   = ((r_state == DRAIN) & r_blk_st) | w_st_full;
  assign err        = r_err;

endmodule

// File: tb/tb_mem_fence_tracker.sv
// Scoreboard bench for mem_fence_tracker: a per-cycle reference model queues
// expected outputs, and a negedge monitor compares them against the DUT.
module tb_mem_fence_tracker;

  localparam int MAX = 8;
  localparam int W   = $clog2(MAX + 1);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fence_req = 1'b0;
  logic [3:0]   fence_pred = 4'b0;
  logic [3:0]   fence_succ = 4'b0;
  logic         fence_ack;
  logic         fence_busy;
  logic         ld_issue = 1'b0;
  logic         ld_done = 1'b0;
  logic         st_issue = 1'b0;
  logic         st_done = 1'b0;
  logic         ld_stall;
  logic         st_stall;
  logic [W-1:0] ld_count;
  logic [W-1:0] st_count;
  logic         err;

  mem_fence_tracker #(.MAX_OUTSTANDING(MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .fence_req (fence_req),
    .fence_pred(fence_pred),
    .fence_succ(fence_succ),
    .fence_ack (fence_ack),
    .fence_busy(fence_busy),
    .ld_issue  (ld_issue),
    .ld_done   (ld_done),
    .st_issue  (st_issue),
    .st_done   (st_done),
    .ld_stall  (ld_stall),
    .st_stall  (st_stall),
    .ld_count  (ld_count),
    .st_count  (st_count),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ack;
    bit busy;
    bit ldStall;
    bit stStall;
    bit err;
    int ldCnt;
    int stCnt;
  } exp_t;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model state: counts as plain integers plus the pending fence.
  int   mLd = 0;
  int   mSt = 0;
  bit   mErr = 0;
  bit   mPend = 0;
  bit   mNeedLd = 0, mNeedSt = 0, mBlkLd = 0, mBlkSt = 0;

  // Requester state: the fence request is held until its ack cycle has passed.
  bit       reqHeld = 0;
  bit [3:0] predHeld = 4'b0;
  bit [3:0] succHeld = 4'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  function automatic bit modelLdStall();
    return (mPend && mBlkLd) || (mLd == MAX);
  endfunction

  function automatic bit modelStStall();
    return (mPend && mBlkSt) || (mSt == MAX);
  endfunction

  task automatic startFence(input bit [3:0] pred, input bit [3:0] succ);
    reqHeld  = 1'b1;
    predHeld = pred;
    succHeld = succ;
  endtask

  // One clock of stimulus; the expected outputs for that cycle go to the scoreboard.
  task automatic applyStimulus(input bit r, input bit ldI, input bit ldD,
                               input bit stI, input bit stD);
    exp_t e;
    bit   drained;
    int   nLd, nSt;
    @(posedge clk);
    #1;
    if (r) reqHeld = 1'b0;
    rst        = r;
    fence_req  = r ? 1'b0 : reqHeld;
    fence_pred = predHeld;
    fence_succ = succHeld;
    ld_issue   = r ? 1'b0 : ldI;
    ld_done    = r ? 1'b0 : ldD;
    st_issue   = r ? 1'b0 : stI;
    st_done    = r ? 1'b0 : stD;
    if (r) begin
      mLd = 0; mSt = 0; mErr = 0; mPend = 0;
      mNeedLd = 0; mNeedSt = 0; mBlkLd = 0; mBlkSt = 0;
      e = '{default: 0};
      expQ.push_back(e);
      return;
    end
    drained   = (!mNeedLd || mLd == 0) && (!mNeedSt || mSt == 0);
    e.busy    = mPend;
    e.ack     = mPend && drained;
    e.ldStall = modelLdStall();
    e.stStall = modelStStall();
    e.err     = mErr;
    e.ldCnt   = mLd;
    e.stCnt   = mSt;
    expQ.push_back(e);
    if (mPend) begin
      if (drained) begin
        mPend   = 1'b0;
        reqHeld = 1'b0;
      end
    end else if (reqHeld) begin
      mPend   = 1'b1;
      mNeedLd = predHeld[3] | predHeld[1];
      mNeedSt = predHeld[2] | predHeld[0];
      mBlkLd  = succHeld[3] | succHeld[1];
      mBlkSt  = succHeld[2] | succHeld[0];
    end
    nLd = mLd + int'(ldI) - int'(ldD);
    nSt = mSt + int'(stI) - int'(stD);
    if (nLd < 0)   begin nLd = 0;   mErr = 1'b1; end
    if (nLd > MAX) begin nLd = MAX; mErr = 1'b1; end
    if (nSt < 0)   begin nSt = 0;   mErr = 1'b1; end
    if (nSt > MAX) begin nSt = MAX; mErr = 1'b1; end
    mLd = nLd;
    mSt = nSt;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: outputs are presented every cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("fence_ack",  int'(fence_ack),  int'(e.ack));
        checkOutput("fence_busy", int'(fence_busy), int'(e.busy));
        checkOutput("ld_stall",   int'(ld_stall),   int'(e.ldStall));
        checkOutput("st_stall",   int'(st_stall),   int'(e.stStall));
        checkOutput("err",        int'(err),        int'(e.err));
        checkOutput("ld_count",   int'(ld_count),   e.ldCnt);
        checkOutput("st_count",   int'(st_count),   e.stCnt);
      end
    end
  end

  initial begin
    bit ldI, ldD, stI, stD;

    $display("[TB] start");
    applyStimulus(1'b1, 0, 0, 0, 0);
    applyStimulus(1'b1, 0, 0, 0, 0);

    // Idle fence acks one cycle after acceptance.
    startFence(4'b0011, 4'b0000);
    idle(4);

    // Store drain with unrelated load retirement.
    applyStimulus(1'b0, 1, 0, 1, 0);
    applyStimulus(1'b0, 1, 0, 1, 0);
    applyStimulus(1'b0, 0, 0, 1, 0);
    startFence(4'b0001, 4'b0000);
    applyStimulus(1'b0, 0, 0, 0, 0);
    applyStimulus(1'b0, 0, 1, 0, 0);
    applyStimulus(1'b0, 0, 0, 0, 1);
    applyStimulus(1'b0, 0, 1, 0, 1);
    idle(1);
    applyStimulus(1'b0, 0, 0, 0, 1);
    idle(3);

    // Successor stall on stores while loads drain.
    applyStimulus(1'b0, 1, 0, 0, 0);
    applyStimulus(1'b0, 1, 0, 0, 0);
    startFence(4'b0010, 4'b0001);
    idle(2);
    applyStimulus(1'b0, 0, 1, 0, 0);
    idle(1);
    applyStimulus(1'b0, 0, 1, 0, 0);
    idle(3);

    // Underflow on an empty load counter.
    applyStimulus(1'b0, 0, 1, 0, 0);
    idle(2);

    // Saturation, then a balanced issue/retire at the limit.
    applyStimulus(1'b1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1, 0, 0, 0);
    idle(1);
    applyStimulus(1'b0, 1, 0, 0, 0);
    applyStimulus(1'b0, 1, 1, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 0, 1, 0, 0);
    idle(1);

    // Reset during a drain aborts it; a fresh fence then acks quickly.
    applyStimulus(1'b1, 0, 0, 0, 0);
    applyStimulus(1'b0, 0, 0, 1, 0);
    applyStimulus(1'b0, 0, 0, 1, 0);
    startFence(4'b0001, 4'b0001);
    idle(3);
    applyStimulus(1'b1, 0, 0, 0, 0);
    startFence(4'b0011, 4'b1100);
    idle(3);

    // Randomized traffic that obeys the issue-path contract.
    applyStimulus(1'b1, 0, 0, 0, 0);
    for (int c = 0; c < 600; c++) begin
      if (!reqHeld && !mPend && ($urandom_range(0, 7) == 0))
        startFence(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      ldI = !modelLdStall() && ($urandom_range(0, 1) == 1);
      stI = !modelStStall() && ($urandom_range(0, 1) == 1);
      ldD = (mLd > 0) && ($urandom_range(0, 2) == 0);
      stD = (mSt > 0) && ($urandom_range(0, 2) == 0);
      applyStimulus(1'b0, ldI, ldD, stI, stD);
    end
    idle(2);

    @(negedge clk);
    #1;
    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_fence_tracker.md
# mem_fence_tracker

Memory-side ordering responder for FENCE. The execute stage decodes FENCE and raises a fence request. This block tracks outstanding loads and stores issued to the memory interface. It withholds acknowledgement until every access class named in the predecessor set has drained, and stalls new accesses in the successor set while the fence is pending. It sits between the execute stage's fence handling and the load/store issue path.

## Interface
Parameters:
- MAX_OUTSTANDING, default 8: maximum in-flight loads, and separately stores. Counter width is $clog2(MAX_OUTSTANDING+1).

Ports:
- clk  in  1  system clock. All state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-high. One clock; reset is asynchronous and active-high.
- fence_req  in  1  fence request. Level signal, held until the handshake completes.
- fence_pred  in  4  predecessor set {I,O,R,W} = instruction bits [27:24]. Sampled at acceptance.
- fence_succ  in  4  successor set {I,O,R,W} = instruction bits [23:20]. Sampled at acceptance.
- fence_ack  out  1  combinational. High in the cycle the fence completes.
- fence_busy  out  1  a fence has been accepted and is draining.
- ld_issue  in  1  one load issued this cycle.
- ld_done  in  1  one load response retired this cycle.
- st_issue  in  1  one store issued this cycle.
- st_done  in  1  one store acknowledged this cycle.
- ld_stall  out  1  issue path must not assert ld_issue.
- st_stall  out  1  issue path must not assert st_issue.
- ld_count  out  W  current outstanding loads.
- st_count  out  W  current outstanding stores.
- err  out  1  sticky protocol error. Cleared only by rst.

## Operation
- Address classes: I merges with R (loads); O merges with W (stores).
  - need_ld = pred[I] | pred[R]; need_st = pred[O] | pred[W].
  - blk_ld = succ[I] | succ[R]; blk_st = succ[O] | succ[W].
- FSM has two states, IDLE and DRAIN.
- IDLE:
  - fence_busy = 0, fence_ack = 0.
  - If fence_req = 1, capture need_ld/need_st/blk_ld/blk_st into registers and go to DRAIN.
- DRAIN:
  - fence_busy = 1.
  - drained = (!need_ld_q | ld_count==0) & (!need_st_q | st_count==0).
  - fence_ack = drained. On the ack cycle, return to IDLE.
- Requester handshake:
  - The requester deasserts fence_req on the edge ending the ack cycle, or presents the next fence.
  - fence_req seen high in IDLE is always a new fence.
- Stall outputs:
  - ld_stall = (DRAIN & blk_ld_q) | (ld_count == MAX_OUTSTANDING).
  - st_stall likewise, using blk_st_q and st_count.
- Counters (per class): next = count + issue − done.
  - Simultaneous issue and done leaves the count unchanged.
  - done while count = 0: count stays 0, err set.
  - issue while count = MAX and no done: count stays MAX, err set.
- The FSM sees only counter values, never the current-cycle issue/done pulses.
- An empty pred mask (pred = 0) drains immediately. Same-cycle issue/done effects on the counters become visible in the next cycle.

## Timing
- Reset values: state IDLE, ld_count = st_count = 0, captured masks 0, err = 0.
  - Outputs during reset: fence_ack = 0, fence_busy = 0, ld_stall = 0, st_stall = 0.
- rst asserted mid-DRAIN aborts the fence with no ack. The requester must reissue.
- Acceptance: fence_req high in IDLE in cycle N puts the block in DRAIN in cycle N+1.
- Minimum latency: fence_ack in cycle N+1, when already drained.
- General latency: ack arrives in the first cycle ≥ N+1 in which the registered counts satisfy drained.
- Done pulse arriving in cycle M that empties the last relevant counter: ack in cycle M+1.
- fence_busy falls one cycle after ack.
- Stall outputs are registered-state functions with no combinational path from the *_issue or *_done inputs.
- Stalls for succ classes rise in cycle N+1 and fall the cycle after ack.

## Structure
- Package fence_pkg holds:
  - mask bit indices FENCE_I = 3, FENCE_O = 2, FENCE_R = 1, FENCE_W = 0;
  - the state enum {IDLE, DRAIN};
  - a function mapping a 4-bit mask to {ld, st} class bits.
- Sub-module outstanding_counter, parameterized by MAX:
  - inputs: inc, dec;
  - outputs: count, full, and a one-cycle err_pulse.
  - Instantiated twice, for loads and stores.
- The top level owns the FSM, the mask registers and the sticky err.

## Test plan
- Idle fence: counts 0, fence_req = 1 with pred = 4'b0011 in cycle 0 → busy = 1 and fence_ack = 1 in cycle 1, IDLE in cycle 2.
- Store drain: 3 st_issue pulses, then fence with pred = W.
  - Required: no ack until the third st_done.
  - Required: ack in the cycle after st_count reaches 0.
  - Required: ld_done activity is ignored.
- Successor stall: fence with pred = R, succ = W, 2 loads outstanding.
  - Required: st_stall = 1 from cycle 1 until the cycle after ack.
  - Required: ld_stall = 0 throughout.
- Saturation: MAX = 8; 8 ld_issue then one more ld_issue.
  - Required: ld_stall = 1 at count 8, count stays 8, err = 1 (sticky).
  - Required: a simultaneous issue and done at count 8 leaves the count at 8 and err unchanged.
- Underflow: ld_done with ld_count = 0 → count stays 0, err = 1.
- Reset mid-drain: rst during DRAIN with st_count = 2.
  - Required immediately, asynchronously: busy = 0, counts 0, no ack.
  - Required after rst deasserts: a new fence acks in 1 cycle.
